// File: rtl/aes_fetch_pkg.sv
// Shared types and constants for the AES block fetcher.
package aes_fetch_pkg;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_BLOCK_W    = 128;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_STALL,
    ST_DRAIN
  } fetch_state_e;

  function automatic int calc_wpb(input int block_w, input int word_w);
    return block_w / word_w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with occupancy count and a registered head so the
// consumer sees a flop output that holds steady while it back-pressures.
module aes_blk_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  // Head tracks the oldest entry: incoming data when it becomes the only
  // entry, otherwise the next stored entry after a pop.
  always_comb begin
    head_d = head_q;
    if (do_push && ((cnt_q == '0) || ((cnt_q == CW'(1)) && do_pop)))
      head_d = wdata_i;
    else if (do_pop && (cnt_q > CW'(1)))
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
      head_q <= head_d;
    end
  end

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != '0);
  assign rdata_o = head_q;

endmodule

// File: rtl/aes_block_fetch.sv
// Streams num_blocks AES blocks from word-wide memory into a block FIFO.
// Define AES_FETCH_BYTESWAP_EN to byte-reverse each word before packing.
module aes_block_fetch
  import aes_fetch_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int BLOCK_W    = DEF_BLOCK_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   num_blocks,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_rd_data,
  output logic               blk_valid,
  output logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_ready
);

  localparam int WPB    = calc_wpb(BLOCK_W, WORD_W);
  localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [WIDX_W-1:0]  cap_idx_q;
  logic               rd_vld_q, rd_en;
  logic               done_q, done_d;
  logic [BLOCK_W-1:0] asm_q, fill;
  logic [WORD_W-1:0]  word_in;
  logic [FCW-1:0]     fifo_count;
  logic [FCW:0]       occ_next;
  logic               push, pop, cap_last, space;

`ifdef AES_FETCH_BYTESWAP_EN
  for (genvar b = 0; b < WORD_W/8; b++) begin : g_swap
    assign word_in[b*8 +: 8] = mem_rd_data[(WORD_W/8-1-b)*8 +: 8];
  end
`else
  assign word_in = mem_rd_data;
`endif

  always_comb begin
    fill = asm_q;
    fill[int'(cap_idx_q)*WORD_W +: WORD_W] = word_in;
  end

  // Final word bypasses the assembly register straight into the FIFO.
  assign cap_last = rd_vld_q && (cap_idx_q == WIDX_W'(WPB-1));
  assign push     = cap_last;
  assign pop      = blk_valid && blk_ready;

  // Occupancy after this edge; covers the block completing now and a
  // same-cycle pop, which are the only blocks not yet counted.
  assign occ_next = {1'b0, fifo_count} + (FCW+1)'(push) - (FCW+1)'(pop);
  assign space    = occ_next < (FCW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    blk_cnt_d = blk_cnt_q;
    widx_d    = widx_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          blk_cnt_d = num_blocks;
          widx_d    = '0;
          if (num_blocks == '0) done_d  = 1'b1;
          else                  state_d = ST_READ;
        end
      end
      ST_READ: begin
        if ((widx_q != '0) || space) begin
          rd_en  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (widx_q == WIDX_W'(WPB-1)) begin
            widx_d    = '0;
            blk_cnt_d = blk_cnt_q - CNT_W'(1);
            if (blk_cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (space) state_d = ST_READ;
      end
      ST_DRAIN: begin
        if (cap_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      blk_cnt_q <= '0;
      widx_q    <= '0;
      cap_idx_q <= '0;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      asm_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      blk_cnt_q <= blk_cnt_d;
      widx_q    <= widx_d;
      rd_vld_q  <= rd_en;
      done_q    <= done_d;
      if (rd_vld_q) begin
        asm_q     <= fill;
        cap_idx_q <= cap_last ? '0 : cap_idx_q + WIDX_W'(1);
      end
    end
  end

  aes_blk_fifo #(
    .W     (BLOCK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (fill),
    .pop_i   (pop),
    .count_o (fifo_count),
    .valid_o (blk_valid),
    .rdata_o (blk_data)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;

endmodule

// File: tb/tb_aes_block_fetch.sv
// Scoreboard bench for aes_block_fetch: stimulus queues expected addresses
// and blocks, a negedge monitor pops and compares them as the DUT emits.
module tb_aes_block_fetch;

  localparam int WORD_W = 32, BLOCK_W = 128, ADDR_W = 10, CNT_W = 16;
  localparam int FIFO_DEPTH = 4, WPB = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  base_addr = '0;
  logic [CNT_W-1:0]   num_blocks = '0;
  logic               busy, done, mem_rd_en, blk_valid;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WORD_W-1:0]  mem_rd_data = '0;
  logic [BLOCK_W-1:0] blk_data;
  logic               blk_ready = 1'b0;

  aes_block_fetch #(
    .WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .ADDR_W(ADDR_W),
    .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] mem [1024];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  logic [BLOCK_W-1:0] exp_blk_q [$];
  logic [ADDR_W-1:0]  exp_addr_q [$];
  int nvec = 0, nmis = 0, rd_cnt = 0;

  function automatic logic [WORD_W-1:0] swz(input logic [WORD_W-1:0] w);
`ifdef AES_FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [BLOCK_W-1:0] model_blk(input logic [ADDR_W-1:0] a);
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < WPB; k++) r[k*WORD_W +: WORD_W] = swz(mem[a + ADDR_W'(k)]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: read addresses, popped blocks, and head stability under stall.
  logic               held_q = 1'b0;
  logic [BLOCK_W-1:0] held_data;
  always @(negedge clk) begin
    if (rst) begin
      held_q = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) chk("rd_addr_unexpected", 128'(mem_addr), '1);
        else chk("rd_addr", 128'(mem_addr), 128'(exp_addr_q.pop_front()));
      end
      if (held_q && blk_valid) chk("blk_hold", blk_data, held_data);
      if (blk_valid && blk_ready) begin
        if (exp_blk_q.size() == 0) chk("blk_unexpected", blk_data, 'x);
        else chk("blk_data", blk_data, exp_blk_q.pop_front());
      end
      held_q    = blk_valid && !blk_ready;
      held_data = blk_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [ADDR_W-1:0] base, input int n, input bit use_model);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < WPB; k++) exp_addr_q.push_back(base + ADDR_W'(b*WPB + k));
      if (use_model) exp_blk_q.push_back(model_blk(base + ADDR_W'(b*WPB)));
    end
    start      = 1'b1;
    base_addr  = base;
    num_blocks = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!done) chk("done_timeout", 128'(done), 128'(1));
  endtask

  int cyc, r0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = WORD_W'(i);
    mem[10'h300] = 32'h11223344;
    mem[10'h301] = 32'h55667788;
    mem[10'h302] = 32'h99AABBCC;
    mem[10'h303] = 32'hDDEEFF00;

    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_en", 128'(mem_rd_en), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_valid", 128'(blk_valid), 128'(0));
    chk("rst_data", blk_data, 128'(0));
    rst = 1'b0;
    tick();

    // single block, continuous ready
    blk_ready = 1'b1;
`ifdef AES_FETCH_BYTESWAP_EN
    exp_blk_q.push_back(128'h13000000_12000000_11000000_10000000);
`else
    exp_blk_q.push_back(128'h00000013_00000012_00000011_00000010);
`endif
    run(10'h010, 1, 1'b0);
    chk("t1_busy_after_start", 128'(busy), 128'(1));
    wait_done(cyc);
    chk("t1_done_latency", 128'(cyc), 128'(6));
    chk("t1_valid_at_done", 128'(blk_valid), 128'(1));
    chk("t1_busy_at_done", 128'(busy), 128'(0));
    tick();
    chk("t1_done_pulse", 128'(done), 128'(0));

    // back-pressure: four blocks buffered, then stall until ready
    blk_ready = 1'b0;
    r0 = rd_cnt;
    run(10'h100, 8, 1'b1);
    repeat (30) tick();
    chk("t2_reads_before_stall", 128'(rd_cnt - r0), 128'(16));
    chk("t2_rd_en_stalled", 128'(mem_rd_en), 128'(0));
    chk("t2_busy_stalled", 128'(busy), 128'(1));
    chk("t2_valid_stalled", 128'(blk_valid), 128'(1));
    blk_ready = 1'b1;
    wait_done(cyc);
    chk("t2_reads_total", 128'(rd_cnt - r0), 128'(32));
    repeat (6) tick();

    // address wrap
    run(10'h3FE, 1, 1'b1);
    wait_done(cyc);
    chk("t3_done_latency", 128'(cyc), 128'(6));
    tick();

    // zero-length run
    r0 = rd_cnt;
    run(10'h000, 0, 1'b1);
    chk("t4_done", 128'(done), 128'(1));
    chk("t4_busy", 128'(busy), 128'(0));
    tick();
    chk("t4_done_pulse", 128'(done), 128'(0));
    chk("t4_no_reads", 128'(rd_cnt - r0), 128'(0));

    // reset mid-run with two blocks buffered
    blk_ready = 1'b0;
    run(10'h200, 4, 1'b1);
    repeat (9) tick();
    chk("t5_valid_before_rst", 128'(blk_valid), 128'(1));
    rst = 1'b1;
    tick();
    chk("t5_valid_after_rst", 128'(blk_valid), 128'(0));
    chk("t5_busy_after_rst", 128'(busy), 128'(0));
    chk("t5_rd_en_after_rst", 128'(mem_rd_en), 128'(0));
    exp_blk_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    tick();
    blk_ready = 1'b1;
    run(10'h040, 2, 1'b1);
    wait_done(cyc);
    tick();

    // word packing (byte order depends on build option)
`ifdef AES_FETCH_BYTESWAP_EN
    exp_blk_q.push_back(128'h00FFEEDD_CCBBAA99_88776655_44332211);
`else
    exp_blk_q.push_back(128'hDDEEFF00_99AABBCC_55667788_11223344);
`endif
    run(10'h300, 1, 1'b0);
    wait_done(cyc);
    repeat (5) tick();

    chk("blk_queue_empty", 128'(exp_blk_q.size()), 128'(0));
    chk("addr_queue_empty", 128'(exp_addr_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
